// File: rtl/bmm_reduce.sv
// bmm_reduce: final modular reduction stage behind a BMM multiplier.
// Takes the unreduced (SIZEM+1)-bit result O and subtracts M repeatedly
// until it drops below M. The result is then held on a valid/ready output.
// M == 0 is flagged through err instead of looping forever.
module bmm_reduce #(
  parameter int SIZEM = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZEM-1:0] M,
  input  logic [SIZEM:0]   O,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SIZEM-1:0] R,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZEM:0]   sub_cnt,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [SIZEM:0]   r_acc;
  logic [SIZEM-1:0] r_mod;
  logic [SIZEM-1:0] r_r;
  logic [SIZEM:0]   r_sub_cnt;
  logic             r_err;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SIZEM:0]   w_mod_ext;
  logic             w_ge;
  logic [SIZEM:0]   w_diff;

  // Compare and subtract are both done at SIZEM+1 bits so O up to 2^(SIZEM+1)-1 works.
  always_comb begin
    w_mod_ext = {1'b0, r_mod};
    w_ge      = (r_acc >= w_mod_ext);
    w_diff    = r_acc - w_mod_ext;
  end

  // Main FSM. All outputs are registered, so in_ready and out_valid always match the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mod       <= '0;
      r_r         <= '0;
      r_sub_cnt   <= '0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sub_cnt <= '0;
            r_mod     <= M;
            if (M == '0) begin
              // A zero modulus would never terminate, so report err with R = 0 at once.
              r_acc       <= '0;
              r_r         <= '0;
              r_err       <= 1'b1;
              r_state     <= S_OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_acc      <= O;
              r_err      <= 1'b0;
              r_state    <= S_SUB;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_SUB: begin
          if (in_valid) begin
            r_ovf <= 1'b1;
          end
          if (w_ge) begin
            // r_mod is nonzero here, so the loop ends within 2^(SIZEM+1)-1 steps.
            // That count still fits in sub_cnt.
            r_acc     <= w_diff;
            r_sub_cnt <= r_sub_cnt + 1'b1;
          end else begin
            r_r         <= r_acc[SIZEM-1:0];
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (in_valid) begin
            r_ovf <= 1'b1;
          end
          // R, sub_cnt and err stay untouched here. They remain stable under backpressure.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Output ports come straight from registers.
  always_comb begin
    in_ready  = r_in_ready;
    out_valid = r_out_valid;
    R         = r_r;
    sub_cnt   = r_sub_cnt;
    err       = r_err;
    ovf       = r_ovf;
  end

endmodule
